// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver (LSB first, idle-high) feeding a small byte FIFO toward the core.
// The core sees {valid, data} and pops with a ready strobe; errors are single-cycle pulses.
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       uart_line_in,
    output logic [8:0] read_byte_out,
    input  logic       read_byte_arg,
    output logic       overrun_out,
    output logic       framing_err_out
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned PW    = AW + 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic [1:0]       r_sync;
    logic             w_line_s;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             w_push;
    logic             w_frame_err;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_wr_en;
    logic             r_overrun;
    logic             r_framing_err;

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], uart_line_in};
        end
    end
    assign w_line_s = r_sync[1];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Start bit is re-checked at its middle; later samples are one bit period apart.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_push      = 1'b0;
        w_frame_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_line_s) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_cnt == CNT_HALF) begin
                    w_cnt_nxt = '0;
                    w_idx_nxt = '0;
                    w_state_nxt = w_line_s ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = '0;
                    w_shift_nxt[r_idx] = w_line_s;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_line_s) begin
                        w_push      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_err = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_WAIT_IDLE: begin
                w_cnt_nxt = '0;
                if (w_line_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = !w_empty && read_byte_arg;
    assign w_wr_en = w_push && (!w_full || w_pop);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_overrun     <= 1'b0;
            r_framing_err <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_overrun     <= w_push && w_full && !w_pop;
            r_framing_err <= w_frame_err;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
        end
    end

    assign read_byte_out   = w_empty ? 9'h000 : {1'b1, r_mem[r_rd_ptr[AW-1:0]]};
    assign overrun_out     = r_overrun;
    assign framing_err_out = r_framing_err;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random frames and random ready,
// checked every cycle against a queue model of the received-byte buffer.
module tb_uart_rx_fifo;
    localparam int BIT   = 16;
    localparam int DEPTH = 4;
    // Stop-bit acceptance cycle after the start edge: 2 sync flops, idle detect, half bit, 9 bits.
    localparam int STOP_SAMPLE = 3 + BIT / 2 + 9 * BIT;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       line;
    logic       rdy;
    logic [8:0] dut_out;
    logic       ov;
    logic       fe;

    logic [7:0] exp_q[$];
    logic       exp_ov_pend = 1'b0;
    logic       exp_fe_pend = 1'b0;
    logic       mon_en = 1'b0;
    logic       rand_rdy = 1'b0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         ov_seen = 0;
    int         fe_seen = 0;
    int         pops = 0;

    uart_rx_fifo #(
        .CLKS_PER_BIT(BIT),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .CLK            (clk),
        .RST_N          (rst_n),
        .uart_line_in   (line),
        .read_byte_out  (dut_out),
        .read_byte_arg  (rdy),
        .overrun_out    (ov),
        .framing_err_out(fe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Per-cycle comparison of the DUT outputs against the model buffer and pending pulses.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            check("valid", 32'(dut_out[8]), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("data", 32'(dut_out[7:0]), 32'(exp_q[0]));
                if (rdy) begin
                    void'(exp_q.pop_front());
                    pops++;
                end
            end
            check("overrun", 32'(ov), 32'(exp_ov_pend));
            check("framing", 32'(fe), 32'(exp_fe_pend));
            exp_ov_pend = 1'b0;
            exp_fe_pend = 1'b0;
            if (ov) ov_seen++;
            if (fe) fe_seen++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) rdy = 1'($urandom_range(0, 1));
        end
    end

    // Drives one frame; nbits < 10 stops part-way. rdy_pulse raises ready for one cycle.
    task automatic send_frame(input logic [7:0] data, input logic stop, input int extra_low,
                              input int nbits, input int rdy_pulse);
        int total;
        total = nbits * BIT + ((!stop && nbits == 10) ? extra_low : 0);
        @(posedge clk);
        #1;
        line = 1'b0;
        for (int cyc = 1; cyc <= total; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == rdy_pulse) rdy = 1'b1;
            if (cyc == rdy_pulse + 1) rdy = 1'b0;
            if (cyc < 10 * BIT && cyc % BIT == 0) begin
                int b;
                b = cyc / BIT;
                line = (b <= 8) ? data[b-1] : stop;
            end
            if (nbits == 10 && cyc == STOP_SAMPLE) begin
                if (stop) begin
                    if (exp_q.size() < DEPTH) exp_q.push_back(data);
                    else exp_ov_pend = 1'b1;
                end else begin
                    exp_fe_pend = 1'b1;
                end
            end
        end
        if (nbits == 10) line = 1'b1;
    endtask

    task automatic drain();
        int n;
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        rdy = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int ov0, fe0, p0;
        rst_n = 1'b0;
        line  = 1'b1;
        rdy   = 1'b0;
        #12;
        check("rst_out", 32'(dut_out), 32'h000);
        check("rst_ov", 32'(ov), 32'd0);
        check("rst_fe", 32'(fe), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (5) @(posedge clk);

        // Two clean frames with ready held high.
        ov0 = ov_seen; fe0 = fe_seen; p0 = pops;
        rdy = 1'b1;
        send_frame(8'h55, 1'b1, 0, 10, -1);
        send_frame(8'hA3, 1'b1, 0, 10, -1);
        repeat (20) @(posedge clk);
        check("t1_pops", 32'(pops - p0), 32'd2);
        check("t1_pulses", 32'(ov_seen - ov0 + fe_seen - fe0), 32'd0);

        // Short low glitch while idle, then a real frame.
        p0 = pops; fe0 = fe_seen;
        @(posedge clk);
        #1;
        line = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        line = 1'b1;
        repeat (30) @(posedge clk);
        check("t2_glitch_pops", 32'(pops - p0), 32'd0);
        check("t2_glitch_fe", 32'(fe_seen - fe0), 32'd0);
        send_frame(8'h0F, 1'b1, 0, 10, -1);
        drain();
        check("t2_pops", 32'(pops - p0), 32'd1);

        // Break: stop bit held low, then recovery.
        p0 = pops; fe0 = fe_seen; ov0 = ov_seen;
        send_frame(8'h3C, 1'b0, 40, 10, -1);
        repeat (10) @(posedge clk);
        check("t3_fe", 32'(fe_seen - fe0), 32'd1);
        check("t3_nobyte", 32'(pops - p0), 32'd0);
        send_frame(8'h81, 1'b1, 0, 10, -1);
        drain();
        check("t3_pops", 32'(pops - p0), 32'd1);
        check("t3_ov", 32'(ov_seen - ov0), 32'd0);

        // Fill past capacity with ready low.
        p0 = pops; ov0 = ov_seen;
        rdy = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0, 10, -1);
        repeat (5) @(posedge clk);
        check("t4_ov", 32'(ov_seen - ov0), 32'd1);
        check("t4_head", 32'(dut_out), 32'h101);
        drain();
        check("t4_pops", 32'(pops - p0), 32'd4);

        // Pop in the exact cycle a byte lands in a full FIFO.
        p0 = pops; ov0 = ov_seen;
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1, 0, 10, -1);
        send_frame(8'h77, 1'b1, 0, 10, STOP_SAMPLE - 1);
        repeat (3) @(posedge clk);
        check("t5_ov", 32'(ov_seen - ov0), 32'd0);
        check("t5_head", 32'(dut_out), 32'h112);
        drain();
        check("t5_pops", 32'(pops - p0), 32'd5);

        // Reset in the middle of a frame with a byte already buffered.
        rdy = 1'b0;
        send_frame(8'h5A, 1'b1, 0, 10, -1);
        repeat (3) @(posedge clk);
        check("t6_pre", 32'(dut_out), 32'h15A);
        send_frame(8'hE7, 1'b1, 0, 5, -1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        exp_ov_pend = 1'b0;
        exp_fe_pend = 1'b0;
        #1;
        check("t6_rst_out", 32'(dut_out), 32'h000);
        check("t6_rst_ov", 32'(ov), 32'd0);
        check("t6_rst_fe", 32'(fe), 32'd0);
        line = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        p0 = pops;
        rdy = 1'b1;
        repeat (3) @(posedge clk);
        send_frame(8'hC6, 1'b1, 0, 10, -1);
        drain();
        check("t6_pops", 32'(pops - p0), 32'd1);

        // Random bytes, occasional broken stop bits, random ready.
        rand_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send_frame(8'($urandom), ($urandom_range(0, 7) != 0), $urandom_range(0, 30), 10, -1);
            repeat ($urandom_range(2, 20)) @(posedge clk);
        end
        drain();
        check("final_empty", 32'(dut_out), 32'h000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
